// File: rtl/wb_stage_seq_pkg.sv
// Shared codes for the writeback stage: op classes, load funct3 codes, FSM states.
package wb_stage_seq_pkg;

  localparam int OP_CODE_W = 9;

  localparam logic [OP_CODE_W-1:0] OP_MRI = 9'h001;
  localparam logic [OP_CODE_W-1:0] OP_IJ  = 9'h002;
  localparam logic [OP_CODE_W-1:0] OP_I2  = 9'h004;
  localparam logic [OP_CODE_W-1:0] OP_U   = 9'h008;
  localparam logic [OP_CODE_W-1:0] OP_J   = 9'h010;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_seq_load_extract.sv
// Load data extraction: picks the byte/half/word lane from the memory word and extends it.
module load_extract
  import wb_stage_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANE_W = $clog2(XLEN/8)
) (
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   word,
  output logic [XLEN-1:0]   value
);

  logic [LANE_W-1:0] off;
  logic [XLEN-1:0]   shifted;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    off = lane & ~LANE_W'(3);
    unique case (funct3)
      F3_LB, F3_LBU: off = lane;
      F3_LH, F3_LHU: off = lane & ~LANE_W'(1);
      default:       off = lane & ~LANE_W'(3);
    endcase
  end

  // Misaligned lane bits below the access size are dropped above, never trapped.
  assign shifted = word >> {off, 3'b000};

  always_comb begin
    value = XLEN'($signed(shifted[31:0]));
    case (funct3)
      F3_LB:   value = XLEN'($signed(shifted[7:0]));
      F3_LBU:  value = XLEN'(shifted[7:0]);
      F3_LH:   value = XLEN'($signed(shifted[15:0]));
      F3_LHU:  value = XLEN'(shifted[15:0]);
      F3_LW:   value = XLEN'($signed(shifted[31:0]));
      F3_LWU:  value = (XLEN == 64) ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      F3_LD:   value = (XLEN == 64) ? word : XLEN'($signed(shifted[31:0]));
      default: value = XLEN'($signed(shifted[31:0]));
    endcase
  end

endmodule

// File: rtl/wb_stage_seq.sv
// Registered writeback stage: selects the result source, waits for load data, drives the RF port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage_seq
  import wb_stage_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int OP_W   = 9,
  parameter int NREG   = 32,
  parameter int RD_W   = $clog2(NREG),
  parameter int LANE_W = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [2:0]        funct3,
  input  logic [RD_W-1:0]   rd,
  input  logic [LANE_W-1:0] addr_lo,
  input  logic [XLEN-1:0]   a_res,
  input  logic [XLEN-1:0]   pc_add_4,
  input  logic [XLEN-1:0]   res_upper_imm,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              load_pending
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  wb_state_e         state;
  logic [RD_W-1:0]   ld_rd;
  logic [2:0]        ld_funct3;
  logic [LANE_W-1:0] ld_lane;
  logic [XLEN-1:0]   sel_data;
  logic [XLEN-1:0]   load_value;
  logic              is_load;

  assign in_ready = (state == WB_IDLE);
  assign is_load  = (op == OP_W'(OP_I2));

  always_comb begin
    sel_data = a_res;
    case (op)
      OP_W'(OP_IJ), OP_W'(OP_J): sel_data = pc_add_4;
      OP_W'(OP_U):               sel_data = res_upper_imm;
      default:                   sel_data = a_res;
    endcase
  end

  load_extract #(
    .XLEN   (XLEN),
    .LANE_W (LANE_W)
  ) u_load_extract (
    .funct3 (ld_funct3),
    .lane   (ld_lane),
    .word   (mem_rsp_data),
    .value  (load_value)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WB_IDLE;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      load_pending <= 1'b0;
      ld_rd        <= '0;
      ld_funct3    <= '0;
      ld_lane      <= '0;
    end else begin
      rf_we <= 1'b0;
      unique case (state)
        WB_IDLE: begin
          if (in_valid) begin
            if (is_load) begin
              ld_rd        <= rd;
              ld_funct3    <= funct3;
              ld_lane      <= addr_lo;
              load_pending <= 1'b1;
              state        <= WB_WAIT_LOAD;
            end else begin
              rf_we    <= (rd != '0);
              rf_waddr <= rd;
              rf_wdata <= sel_data;
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (mem_rsp_valid) begin
            rf_we        <= (ld_rd != '0);
            rf_waddr     <= ld_rd;
            rf_wdata     <= load_value;
            load_pending <= 1'b0;
            state        <= WB_IDLE;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  logic wb_done;

  // Counts completions regardless of the rd==0 write mask.
  assign wb_done = ((state == WB_IDLE) && in_valid && !is_load) ||
                   ((state == WB_WAIT_LOAD) && mem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret <= '0;
    else if (wb_done) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage_seq.sv
// Self-checking bench for wb_stage_seq: vector table, corner sequences, randomized model comparison.
module tb_wb_stage_seq;
  import wb_stage_seq_pkg::*;

  localparam logic [8:0] OP_BAD = 9'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  addr_lo;
  logic [31:0] a_res;
  logic [31:0] pc_add_4;
  logic [31:0] res_upper_imm;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_pending;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  wb_stage_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .funct3        (funct3),
    .rd            (rd),
    .addr_lo       (addr_lo),
    .a_res         (a_res),
    .pc_add_4      (pc_add_4),
    .res_upper_imm (res_upper_imm),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .load_pending  (load_pending)
`ifdef WB_INSTRET_EN
    ,
    .instret       (instret)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [8:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [1:0]  lane;
    logic [31:0] a;
    logic [31:0] pc4;
    logic [31:0] ui;
    logic [31:0] mem;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result computed from the op-class and load rules with plain arithmetic.
  function automatic logic [31:0] model(input vec_t v);
    longint size, off, val, span;
    if (v.op == OP_I2) begin
      size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
      off  = longint'(v.lane) - (longint'(v.lane) % size);
      span = longint'(1) << (8 * size);
      val  = (longint'(v.mem) >> (8 * off)) % span;
      if (!v.f3[2] && val >= span / 2) val = val - span;
      return val[31:0];
    end
    if (v.op == OP_MRI) return v.a;
    if (v.op == OP_IJ || v.op == OP_J) return v.pc4;
    if (v.op == OP_U) return v.ui;
    return v.a;
  endfunction

  task automatic drive(input vec_t v);
    op            = v.op;
    funct3        = v.f3;
    rd            = v.rd;
    addr_lo       = v.lane;
    a_res         = v.a;
    pc_add_4      = v.pc4;
    res_upper_imm = v.ui;
  endtask

  // One accept, optional wait, response, and the completion check.
  task automatic run_txn(input vec_t v, input int delay, input string tag);
    drive(v);
    in_valid = 1'b1;
    check({tag, " in_ready at accept"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    if (v.op == OP_I2) begin
      for (int i = 0; i < delay; i++) begin
        check({tag, " pending"}, {62'd0, in_ready, load_pending}, 64'b01);
        check({tag, " no early we"}, 64'(rf_we), 64'd0);
        tick();
      end
      check({tag, " pending"}, {62'd0, in_ready, load_pending}, 64'b01);
      mem_rsp_data  = v.mem;
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    check({tag, " rf_we"}, 64'(rf_we), 64'(v.exp_we));
    check({tag, " rf_waddr"}, 64'(rf_waddr), 64'(v.rd));
    check({tag, " rf_wdata"}, 64'(rf_wdata), 64'(v.exp_wdata));
    check({tag, " idle after"}, {62'd0, in_ready, load_pending}, 64'b10);
    tick();
    check({tag, " we pulse ends"}, 64'(rf_we), 64'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0; funct3 = '0; rd = '0; addr_lo = '0;
    a_res = '0; pc_add_4 = '0; res_upper_imm = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    //           op      f3  rd    lane a             pc4           ui            mem           we    wdata
    vecs[0]  = '{OP_MRI, 3'd0, 5'd5,  2'd0, 32'h12345678, 32'h0,        32'h0,        32'h0,        1'b1, 32'h12345678};
    vecs[1]  = '{OP_J,   3'd0, 5'd1,  2'd0, 32'h0,        32'h00000104, 32'h0,        32'h0,        1'b1, 32'h00000104};
    vecs[2]  = '{OP_U,   3'd0, 5'd2,  2'd0, 32'h0,        32'h0,        32'hABCD0000, 32'h0,        1'b1, 32'hABCD0000};
    vecs[3]  = '{OP_IJ,  3'd0, 5'd31, 2'd0, 32'h11111111, 32'h00002008, 32'h22222222, 32'h0,        1'b1, 32'h00002008};
    vecs[4]  = '{OP_BAD, 3'd0, 5'd9,  2'd0, 32'hCAFEF00D, 32'h00000004, 32'h33333333, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[5]  = '{OP_I2,  3'd0, 5'd7,  2'd3, 32'h0,        32'h0,        32'h0,        32'h80FF0000, 1'b1, 32'hFFFFFF80};
    vecs[6]  = '{OP_I2,  3'd5, 5'd4,  2'd2, 32'h0,        32'h0,        32'h0,        32'h9ABC1234, 1'b1, 32'h00009ABC};
    vecs[7]  = '{OP_I2,  3'd5, 5'd0,  2'd2, 32'h0,        32'h0,        32'h0,        32'h9ABC1234, 1'b0, 32'h00009ABC};
    vecs[8]  = '{OP_I2,  3'd1, 5'd3,  2'd3, 32'h0,        32'h0,        32'h0,        32'h80010000, 1'b1, 32'hFFFF8001};
    vecs[9]  = '{OP_I2,  3'd4, 5'd6,  2'd1, 32'h0,        32'h0,        32'h0,        32'h0000F200, 1'b1, 32'h000000F2};
    vecs[10] = '{OP_I2,  3'd3, 5'd8,  2'd1, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{OP_MRI, 3'd0, 5'd0,  2'd0, 32'h55AA55AA, 32'h0,        32'h0,        32'h0,        1'b0, 32'h55AA55AA};

    repeat (2) tick();
    check("reset rf_we", 64'(rf_we), 64'd0);
    check("reset rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset in_ready/pending", {62'd0, in_ready, load_pending}, 64'b10);
`ifdef WB_INSTRET_EN
    check("reset instret", instret, 64'd0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i], i % 3, $sformatf("vec%0d", i));

    // Back-to-back J then U.
    drive(vecs[1]);
    in_valid = 1'b1;
    tick();
    check("b2b J we/addr", {58'd0, rf_we, rf_waddr}, {58'd0, 1'b1, 5'd1});
    check("b2b J data", 64'(rf_wdata), 64'h104);
    check("b2b in_ready", 64'(in_ready), 64'd1);
    drive(vecs[2]);
    tick();
    in_valid = 1'b0;
    check("b2b U we/addr", {58'd0, rf_we, rf_waddr}, {58'd0, 1'b1, 5'd2});
    check("b2b U data", 64'(rf_wdata), 64'hABCD0000);
    tick();
    check("b2b end", 64'(rf_we), 64'd0);

    // Response pulsed in the accept cycle is ignored.
    drive(vecs[5]);
    in_valid = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    check("accept-rsp ignored we", 64'(rf_we), 64'd0);
    check("accept-rsp pending", 64'(load_pending), 64'd1);
    tick();
    check("accept-rsp still waiting", {62'd0, in_ready, load_pending}, 64'b01);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h80FF0000;
    tick();
    mem_rsp_valid = 1'b0;
    check("accept-rsp late write", {31'd0, rf_we, rf_wdata}, {31'd0, 1'b1, 32'hFFFFFF80});
    tick();

    // Reset while waiting abandons the load.
    drive(vecs[6]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre-reset pending", 64'(load_pending), 64'd1);
    rst = 1'b1;
    #2;
    check("async reset pending", {62'd0, in_ready, load_pending}, 64'b10);
    #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h12345678;
    tick();
    mem_rsp_valid = 1'b0;
    check("rsp after reset ignored", {61'd0, rf_we, in_ready, load_pending}, 64'b010);
    check("rsp after reset wdata", 64'(rf_wdata), 64'd0);
`ifdef WB_INSTRET_EN
    check("instret after reset", instret, 64'd0);
    run_txn(vecs[0], 0, "cnt0");
    run_txn(vecs[7], 1, "cnt1");
    run_txn(vecs[11], 0, "cnt2");
    check("instret after three", instret, 64'd3);
`endif

    // Randomized transactions against the reference model.
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel    = $urandom_range(0, 7);
      v.op   = (sel == 0) ? OP_MRI : (sel == 1) ? OP_IJ : (sel == 2) ? OP_J :
               (sel == 3) ? OP_U : (sel == 4) ? 9'($urandom) : OP_I2;
      v.f3   = 3'($urandom);
      v.rd   = 5'($urandom);
      v.lane = 2'($urandom);
      v.a    = $urandom;
      v.pc4  = $urandom;
      v.ui   = $urandom;
      v.mem  = $urandom;
      v.exp_we    = (v.rd != 5'd0);
      v.exp_wdata = model(v);
      run_txn(v, $urandom_range(0, 3), $sformatf("rnd%0d op%0h f3%0d l%0d", n, v.op, v.f3, v.lane));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
